// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: rebuilds a scanned 7-segment display into stable BCD frames on a valid/ready stream.
// Defining SEG_BIN_EN adds a CONVERT state and the bin_out port carrying the binary value of the frame.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_FRAMES = 2,
  parameter int BIN_W         = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic                    sample_en,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef SEG_BIN_EN
  ,
  output logic [BIN_W-1:0]        bin_out
`endif
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_COMPARE = 2'd1,
    ST_CONVERT = 2'd2,
    ST_PUBLISH = 2'd3
  } state_e;

  localparam logic [3:0]            STABLE_TGT = 4'(STABLE_FRAMES);
  localparam logic [NUM_DIGITS-1:0] MASK_FULL  = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] MASK_NONE  = {NUM_DIGITS{1'b0}};

  // Returns {err, nibble}: digits 0-9, blank as 4'hA, anything else 4'hF with err.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h7E:   r = {1'b0, 4'h0};
      7'h30:   r = {1'b0, 4'h1};
      7'h6D:   r = {1'b0, 4'h2};
      7'h79:   r = {1'b0, 4'h3};
      7'h33:   r = {1'b0, 4'h4};
      7'h5B:   r = {1'b0, 4'h5};
      7'h5F:   r = {1'b0, 4'h6};
      7'h70:   r = {1'b0, 4'h7};
      7'h7F:   r = {1'b0, 4'h8};
      7'h7B:   r = {1'b0, 4'h9};
      7'h00:   r = {1'b0, 4'hA};
      default: r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  state_e                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] work_bcd_q, work_bcd_d;
  logic [NUM_DIGITS-1:0]   work_err_q, work_err_d;
  logic [4*NUM_DIGITS-1:0] prev_bcd_q, prev_bcd_d;
  logic [NUM_DIGITS-1:0]   prev_err_q, prev_err_d;
  logic [3:0]              stable_q, stable_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    valid_q, valid_d;
`ifdef SEG_BIN_EN
  logic [BIN_W-1:0]        acc_q, acc_d;
  logic [BIN_W-1:0]        bin_q, bin_d;
  logic [3:0]              conv_idx_q, conv_idx_d;
  logic [3:0]              conv_dig_s;
`endif

  logic [4:0] dec_s;
  logic [3:0] sel_cnt_s;
  logic       sel_onehot_s;
  logic       frame_match_s;

  assign dec_s         = decode_seg(seg_in);
  assign frame_match_s = (work_bcd_q == prev_bcd_q) && (work_err_q == prev_err_q);

  // Digit select must have exactly one bit set to address a slot.
  always_comb begin
    sel_cnt_s = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_cnt_s = sel_cnt_s + {3'b000, an_in[i]};
    end
    sel_onehot_s = (sel_cnt_s == 4'd1);
  end

`ifdef SEG_BIN_EN
  // Digit currently being folded into the accumulator; blank and error count as zero.
  always_comb begin
    conv_dig_s = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (4'(i) == conv_idx_q) begin
        conv_dig_s = (prev_bcd_q[4*i +: 4] <= 4'd9) ? prev_bcd_q[4*i +: 4] : 4'd0;
      end else begin
        conv_dig_s = conv_dig_s;
      end
    end
  end
`endif

  // Next-state and datapath for the collect/compare/convert/publish sequence.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    work_bcd_d = work_bcd_q;
    work_err_d = work_err_q;
    prev_bcd_d = prev_bcd_q;
    prev_err_d = prev_err_q;
    stable_d   = stable_q;
    bcd_d      = bcd_q;
    err_d      = err_q;
    valid_d    = valid_q;
`ifdef SEG_BIN_EN
    acc_d      = acc_q;
    bin_d      = bin_q;
    conv_idx_d = conv_idx_q;
`endif
    case (state_q)
      ST_COLLECT: begin
        if (sample_en && sel_onehot_s) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_in[i]) begin
              work_bcd_d[4*i +: 4] = dec_s[3:0];
              work_err_d[i]        = dec_s[4];
            end else begin
              work_err_d[i]        = work_err_d[i];
            end
          end
          mask_d = mask_q | an_in;
        end else begin
          mask_d = mask_q;
        end
        if (mask_d == MASK_FULL) begin
          state_d = ST_COMPARE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_COMPARE: begin
        mask_d = MASK_NONE;
        if (frame_match_s) begin
          stable_d = (stable_q == 4'd15) ? 4'd15 : stable_q + 4'd1;
        end else begin
          prev_bcd_d = work_bcd_q;
          prev_err_d = work_err_q;
          stable_d   = 4'd1;
        end
        // A saturated count must not republish an unchanged display.
        if ((stable_d == STABLE_TGT) && !(frame_match_s && (stable_q == 4'd15))) begin
`ifdef SEG_BIN_EN
          state_d    = ST_CONVERT;
          acc_d      = {BIN_W{1'b0}};
          conv_idx_d = 4'(NUM_DIGITS - 1);
`else
          state_d    = ST_PUBLISH;
`endif
        end else begin
          state_d = ST_COLLECT;
        end
      end
`ifdef SEG_BIN_EN
      ST_CONVERT: begin
        acc_d = (acc_q << 3) + (acc_q << 1) + {{(BIN_W-4){1'b0}}, conv_dig_s};
        if (conv_idx_q == 4'd0) begin
          state_d = ST_PUBLISH;
        end else begin
          conv_idx_d = conv_idx_q - 4'd1;
        end
      end
`endif
      ST_PUBLISH: begin
        if (!valid_q) begin
          bcd_d   = prev_bcd_q;
          err_d   = prev_err_q;
          valid_d = 1'b1;
`ifdef SEG_BIN_EN
          bin_d   = acc_q;
`endif
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_COLLECT;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        mask_d  = MASK_NONE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_COLLECT;
      mask_q     <= MASK_NONE;
      work_bcd_q <= {(4*NUM_DIGITS){1'b0}};
      work_err_q <= MASK_NONE;
      prev_bcd_q <= {(4*NUM_DIGITS){1'b0}};
      prev_err_q <= MASK_NONE;
      stable_q   <= 4'd0;
      bcd_q      <= {(4*NUM_DIGITS){1'b0}};
      err_q      <= MASK_NONE;
      valid_q    <= 1'b0;
`ifdef SEG_BIN_EN
      acc_q      <= {BIN_W{1'b0}};
      bin_q      <= {BIN_W{1'b0}};
      conv_idx_q <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      work_bcd_q <= work_bcd_d;
      work_err_q <= work_err_d;
      prev_bcd_q <= prev_bcd_d;
      prev_err_q <= prev_err_d;
      stable_q   <= stable_d;
      bcd_q      <= bcd_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
`ifdef SEG_BIN_EN
      acc_q      <= acc_d;
      bin_q      <= bin_d;
      conv_idx_q <= conv_idx_d;
`endif
    end
  end

  assign bcd_out   = bcd_q;
  assign err_out   = err_q;
  assign out_valid = valid_q;
`ifdef SEG_BIN_EN
  assign bin_out   = bin_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: randomized scan order and noise, checked against a frame-level model.
`timescale 1ns/1ps
module tb_seg7_scan_decoder;
  localparam int ND = 4;
  localparam int SF = 2;
  localparam int BW = 14;
`ifdef SEG_BIN_EN
  localparam int LAT = 2 + ND;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    seg_in = 7'h00;
  logic [ND-1:0] an_in = '0;
  logic          sample_en = 1'b0;
  logic          out_ready = 1'b0;
  logic [4*ND-1:0] bcd_out;
  logic [ND-1:0] err_out;
  logic          out_valid;
`ifdef SEG_BIN_EN
  logic [BW-1:0] bin_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  // frame-level model: run length of identical consecutive complete frames
  bit              have_last;
  logic [4*ND-1:0] last_bcd;
  logic [ND-1:0]   last_err;
  int              run;
  logic [4*ND-1:0] cap_bcd;
  logic [ND-1:0]   cap_err;
  logic [BW-1:0]   cap_bin;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_FRAMES(SF), .BIN_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in), .sample_en(sample_en),
    .bcd_out(bcd_out), .err_out(err_out), .out_valid(out_valid), .out_ready(out_ready)
`ifdef SEG_BIN_EN
    , .bin_out(bin_out)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_decode(input logic [6:0] pat);
    if (pat == 7'h00) return {1'b0, 4'hA};
    for (int k = 0; k < 10; k++) if (pat == seg_tab[k]) return {1'b0, 4'(k)};
    return {1'b1, 4'hF};
  endfunction

  function automatic logic [7*ND-1:0] pats_of(input logic [15:0] v);
    logic [7*ND-1:0] p;
    for (int d = 0; d < ND; d++) p[7*d +: 7] = seg_tab[v[4*d +: 4]];
    return p;
  endfunction

  function automatic logic [6:0] rand_pat();
    int r;
    r = $urandom_range(0, 12);
    if (r < 10) return seg_tab[r];
    else if (r == 10) return 7'h00;
    else if (r == 11) return 7'h01;
    else return 7'h77;
  endfunction

  task automatic model_reset();
    have_last = 1'b0;
    run = 0;
  endtask

  task automatic send_frame(input logic [7*ND-1:0] pats, input bit inject_bad, input bit dup, input string name);
    int order [ND];
    logic [4*ND-1:0] fb;
    logic [ND-1:0] fe;
    logic [4:0] dv;
    logic [BW-1:0] eb;
    int fbin, p, first, j, tmp;
    bit pub;
    fbin = 0;
    p = 1;
    for (int d = 0; d < ND; d++) begin
      dv = ref_decode(pats[7*d +: 7]);
      fb[4*d +: 4] = dv[3:0];
      fe[d] = dv[4];
      if (dv[3:0] <= 4'd9) fbin += int'(dv[3:0]) * p;
      p *= 10;
    end
    eb = fbin[BW-1:0];
    if (have_last && fb == last_bcd && fe == last_err) run++;
    else run = 1;
    have_last = 1'b1;
    last_bcd = fb;
    last_err = fe;
    pub = (run == SF);

    for (int i = 0; i < ND; i++) order[i] = i;
    for (int i = ND - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    if (dup) begin
      @(negedge clk);
      an_in = '0; an_in[2] = 1'b1; seg_in = pats[14 +: 7] ^ 7'h15; sample_en = 1'b1;
    end
    for (int i = 0; i < ND; i++) begin
      if (inject_bad) begin
        @(negedge clk);
        an_in = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b0110;
        seg_in = 7'($urandom); sample_en = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        sample_en = 1'b0; an_in = '0; seg_in = 7'($urandom);
      end
      @(negedge clk);
      an_in = '0; an_in[order[i]] = 1'b1; seg_in = pats[7*order[i] +: 7]; sample_en = 1'b1;
    end
    first = -1;
    for (int c = 0; c <= LAT + 2; c++) begin
      @(negedge clk);
      if (c == 0) begin sample_en = 1'b0; an_in = '0; end
      if (out_valid === 1'b1 && first < 0) begin
        first = c;
        cap_bcd = bcd_out;
        cap_err = err_out;
`ifdef SEG_BIN_EN
        cap_bin = bin_out;
`endif
      end
    end
    n_checks++;
    if (pub && first != LAT) begin
      n_fail++; $display("FAIL %s_latency: got cycle %0d expected %0d", name, first, LAT);
    end else if (!pub && first != -1) begin
      n_fail++; $display("FAIL %s_spurious_publish: got publish at %0d value %h expected none", name, first, cap_bcd);
    end
    if (pub && first >= 0) begin
      n_checks++;
      if (cap_bcd !== fb) begin n_fail++; $display("FAIL %s_bcd: got %h expected %h", name, cap_bcd, fb); end
      n_checks++;
      if (cap_err !== fe) begin n_fail++; $display("FAIL %s_err: got %b expected %b", name, cap_err, fe); end
`ifdef SEG_BIN_EN
      n_checks++;
      if (cap_bin !== eb) begin n_fail++; $display("FAIL %s_bin: got %0d expected %0d", name, cap_bin, eb); end
`endif
    end
    if (out_ready) begin
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_valid_drop: got %b expected 0", name, out_valid); end
    end
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (bcd_out !== '0) begin n_fail++; $display("FAIL %s_bcd: got %h expected 0", name, bcd_out); end
    n_checks++;
    if (err_out !== '0) begin n_fail++; $display("FAIL %s_err: got %b expected 0", name, err_out); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_valid: got %b expected 0", name, out_valid); end
`ifdef SEG_BIN_EN
    n_checks++;
    if (bin_out !== '0) begin n_fail++; $display("FAIL %s_bin: got %0d expected 0", name, bin_out); end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset_init");
    rst_n = 1'b1;
    model_reset();
    send_frame(pats_of(16'h4321), 1'b0, 1'b0, "pre_reset_a");
    send_frame(pats_of(16'h4321), 1'b0, 1'b0, "pre_reset_b");
    @(negedge clk);
    an_in = 4'b0001; seg_in = seg_tab[9]; sample_en = 1'b1;
    @(negedge clk);
    an_in = 4'b0010; seg_in = seg_tab[8];
    @(negedge clk);
    sample_en = 1'b0; an_in = '0;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send_frame(pats_of(16'h1234), 1'b0, 1'b0, "post_reset_a");
    send_frame(pats_of(16'h1234), 1'b0, 1'b0, "post_reset_b");
    n_checks++;
    if (cap_bcd !== 16'h1234) begin n_fail++; $display("FAIL post_reset_value: got %h expected 1234", cap_bcd); end
  endtask

  task automatic test_stability();
    send_frame(pats_of(16'h1234), 1'b0, 1'b0, "stab_1234");
    send_frame(pats_of(16'h1235), 1'b0, 1'b0, "stab_1235_a");
    send_frame(pats_of(16'h1235), 1'b0, 1'b0, "stab_1235_b");
    n_checks++;
    if (cap_bcd !== 16'h1235) begin n_fail++; $display("FAIL stab_value: got %h expected 1235", cap_bcd); end
    send_frame(pats_of(16'h1235), 1'b0, 1'b0, "stab_1235_c");
    send_frame(pats_of(16'h1235), 1'b0, 1'b0, "stab_1235_d");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_frame(pats_of(16'h2468), 1'b0, 1'b0, "bp_a");
    send_frame(pats_of(16'h2468), 1'b0, 1'b0, "bp_b");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      an_in = '0; an_in[c % ND] = 1'b1; seg_in = rand_pat(); sample_en = 1'b1;
      n_checks++;
      if (bcd_out !== 16'h2468 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold: got %h valid %b expected 2468 valid 1", bcd_out, out_valid);
      end
    end
    @(negedge clk);
    sample_en = 1'b0; an_in = '0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b expected 0", out_valid); end
    send_frame(pats_of(16'h1357), 1'b0, 1'b0, "bp_new_a");
    send_frame(pats_of(16'h1357), 1'b0, 1'b0, "bp_new_b");
  endtask

  task automatic test_decode();
    logic [7*ND-1:0] p;
    p = {7'h00, 7'h7B, 7'h01, 7'h7E};
    send_frame(p, 1'b0, 1'b0, "dec_a");
    send_frame(p, 1'b0, 1'b0, "dec_b");
    n_checks++;
    if (cap_bcd !== 16'hA9F0 || cap_err !== 4'b0010) begin
      n_fail++; $display("FAIL dec_value: got %h/%b expected a9f0/0010", cap_bcd, cap_err);
    end
`ifdef SEG_BIN_EN
    n_checks++;
    if (cap_bin !== 14'd900) begin n_fail++; $display("FAIL dec_bin: got %0d expected 900", cap_bin); end
`endif
  endtask

  task automatic test_select_errors();
    send_frame(pats_of(16'h1234), 1'b1, 1'b1, "sel_a");
    send_frame(pats_of(16'h1234), 1'b1, 1'b1, "sel_b");
    n_checks++;
    if (cap_bcd !== 16'h1234) begin n_fail++; $display("FAIL sel_value: got %h expected 1234", cap_bcd); end
  endtask

  task automatic test_random();
    logic [7*ND-1:0] set [3];
    int idx;
    for (int s = 0; s < 3; s++)
      for (int d = 0; d < ND; d++) set[s][7*d +: 7] = rand_pat();
    idx = 0;
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 1) == 0) idx = $urandom_range(0, 2);
      send_frame(set[idx], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_stability();
    test_backpressure();
    test_decode();
    test_select_errors();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive side of the 7-segment interface: reads a multiplexed (scanned) display bus of segment pattern plus digit select, and rebuilds the displayed multi-digit BCD value.
- Only publishes frames that are stable across scans.
- Used for loopback checking of the CNN result display path and for on-chip capture of displayed class digits.
- Output is a valid/ready stream.

Parameters:
- NUM_DIGITS, 4, number of scanned digits (1..8).
- STABLE_FRAMES, 2, consecutive identical complete frames required before publishing (1..15).
- BIN_W, 14, width of the binary output when SEG_BIN_EN is defined; must hold 10^NUM_DIGITS-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_in  in  7  segment pattern, bit6=a … bit0=g, active high.
- an_in  in  NUM_DIGITS  digit select, one-hot active high; bit i = digit i, digit 0 least significant.
- sample_en  in  1  seg_in/an_in are stable this cycle; sample them.
- bcd_out  out  4*NUM_DIGITS  published digits; nibble i = digit i.
- err_out  out  NUM_DIGITS  bit i set = digit i pattern was not decodable.
- out_valid  out  1  published frame available.
- out_ready  in  1  consumer accepts frame.
- bin_out  out  BIN_W  binary value of bcd_out; present only with SEG_BIN_EN.

Behaviour:
- Reset (async, rst_n=0):
  - bcd_out=0, err_out=0, out_valid=0, bin_out=0.
  - Capture mask, working and previous-frame registers, and stable count cleared.
  - State = COLLECT.
  - Reset mid-operation discards any partial frame and any pending output.
- Pattern decode:
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9.
  - 00 (blank) → 4'hA, not an error.
  - Any other pattern → 4'hF with the error bit set.
- COLLECT:
  - On sample_en=1 with an_in exactly one-hot: the decoded nibble and error bit are written to slot i and mask bit i is set.
  - A repeat sample of the same slot overwrites it.
  - sample_en with an_in zero or multi-hot is ignored.
  - When the mask reaches all ones (including the cycle that completes it), go to COMPARE next cycle.
- COMPARE (1 cycle):
  - If the working frame equals the previous frame: stable_cnt++, saturating at 15.
  - Otherwise: previous ← working, stable_cnt=1.
  - Mask cleared.
  - If stable_cnt (after update) == STABLE_FRAMES: go to CONVERT (with SEG_BIN_EN) or PUBLISH. Otherwise go to COLLECT.
  - The publish check is equality, not ≥, so an unchanged display publishes once; a later change publishes again after it restabilises.
- CONVERT: see Optional Feature.
- PUBLISH:
  - Output registers are loaded on entry; out_valid=1.
  - bcd_out, err_out and bin_out are held constant while out_valid=1 && out_ready=0.
  - The transfer completes on the cycle with out_valid && out_ready; out_valid drops the next cycle and the state returns to COLLECT.
- Samples are dropped in all states except COLLECT. The mask is always empty on re-entry to COLLECT.
- Latency: with sample_en completing the frame at edge t, out_valid rises at edge t+2 (t+2+NUM_DIGITS with SEG_BIN_EN).
- NUM_DIGITS=1: every valid sample completes a frame.

Optional Feature:
- Macro: SEG_BIN_EN.
- Defined:
  - bin_out port exists.
  - CONVERT state lasts NUM_DIGITS cycles, MSD first: acc ← acc*10 + d. Multiply is done as (acc<<3)+(acc<<1). Blank (A) and error (F) digits count as 0.
  - bin_out is loaded with acc on entry to PUBLISH.
- Undefined: no bin_out port and no CONVERT state; COMPARE goes directly to PUBLISH.

Test Plan:
- Reset:
  - rst_n low mid-COLLECT with 2 slots filled → all outputs 0.
  - After release, a full scan of "1234" ×2 → bcd_out=16'h1234, err_out=0, out_valid high at +2 cycles (bin_out=1234 when defined).
- Stability:
  - Scan 1234, then 1235, then 1235 with STABLE_FRAMES=2 → single publish of 16'h1235; 1234 never appears.
  - Further 1235 scans → no re-publish.
- Backpressure:
  - out_ready=0 for 20 cycles while the display changes → bcd_out constant.
  - out_ready pulse → out_valid low the next cycle.
  - A new value publishes only after 2 fresh stable frames.
- Decode:
  - Digit patterns 7'h00, 7'h7B, 7'h01, 7'h7E (d3..d0) ×2 → bcd_out=16'hA9F0, err_out=4'b0010, bin_out=900.
- Select errors:
  - an_in=4'b0000 and 4'b0110 samples interleaved in a valid scan → ignored; output matches the valid scan.
  - Duplicate sample of digit 2 with a new pattern before the frame completes → the last value is used.
